// File: rtl/axis_frame_arb.sv
// Frame-level round-robin arbiter: S_COUNT AXI4-Stream sources onto one registered sink.
// Optional stall timeout with bad-frame termination: define AXIS_FRAME_ARB_TIMEOUT_EN.
module axis_frame_arb #(
  parameter int S_COUNT = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH = (DATA_WIDTH / 8),
  parameter int USER_WIDTH = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter int TIMEOUT = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [S_COUNT-1:0]              s_axis_tvalid,
  output logic [S_COUNT-1:0]              s_axis_tready,
  input  logic [S_COUNT-1:0]              s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,
  output logic                            grant_valid,
  output logic [$clog2(S_COUNT)-1:0]      grant_index
);

  localparam int IW = $clog2(S_COUNT);

`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StActive, StTerm, StDrop} state_e;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_q;
  logic          load_term;
  logic          unused_in;
  assign unused_in = ^s_axis_tkeep;
`else
  typedef enum logic [1:0] {StIdle, StActive} state_e;
  logic unused_in;
  assign unused_in = ^{s_axis_tkeep, USER_BAD_FRAME_VALUE, 32'(TIMEOUT)};
`endif

  state_e                  state_q;
  logic                    grant_valid_q;
  logic [IW-1:0]           grant_index_q;
  logic [IW-1:0]           ptr_q;
  logic                    m_tvalid_q;
  logic [DATA_WIDTH-1:0]   m_tdata_q;
  logic [KEEP_WIDTH-1:0]   m_tkeep_q;
  logic                    m_tlast_q;
  logic [USER_WIDTH-1:0]   m_tuser_q;

  logic                    arb_found;
  logic [IW-1:0]           arb_idx;
  logic                    g_valid;
  logic                    g_last;
  logic [DATA_WIDTH-1:0]   g_data;
  logic [KEEP_WIDTH-1:0]   g_keep;
  logic [USER_WIDTH-1:0]   g_user;
  logic                    out_free;
  logic                    load_beat;

  // First requester strictly after the pointer, wrapping around.
  always_comb begin
    logic [IW-1:0] cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= S_COUNT; i++) begin
      cand = IW'((int'(ptr_q) + i) % S_COUNT);
      if (!arb_found && s_axis_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign g_valid   = s_axis_tvalid[grant_index_q];
  assign g_last    = s_axis_tlast[grant_index_q];
  assign g_data    = s_axis_tdata[int'(grant_index_q)*DATA_WIDTH +: DATA_WIDTH];
  assign g_keep    = s_axis_tkeep[int'(grant_index_q)*KEEP_WIDTH +: KEEP_WIDTH];
  assign g_user    = s_axis_tuser[int'(grant_index_q)*USER_WIDTH +: USER_WIDTH];
  assign out_free  = !m_tvalid_q || m_axis_tready;
  assign load_beat = (state_q == StActive) && g_valid && out_free;
`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
  assign load_term = (state_q == StTerm) && out_free;
`endif

  always_comb begin
    s_axis_tready = '0;
    case (state_q)
      StActive: s_axis_tready[grant_index_q] = out_free;
`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
      StDrop:   s_axis_tready[grant_index_q] = 1'b1;
`endif
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      ptr_q         <= IW'(S_COUNT - 1);
      m_tvalid_q    <= 1'b0;
`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
      stall_q       <= '0;
`endif
    end else begin
      // Output register drains in every state; a new load below overrides.
      if (m_axis_tready) m_tvalid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (arb_found) begin
            grant_index_q <= arb_idx;
            ptr_q         <= arb_idx;
            grant_valid_q <= 1'b1;
            state_q       <= StActive;
`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
            stall_q       <= '0;
`endif
          end
        end
        StActive: begin
          if (load_beat) begin
            m_tvalid_q <= 1'b1;
`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
            stall_q    <= '0;
`endif
            if (g_last) begin
              grant_valid_q <= 1'b0;
              state_q       <= StIdle;
            end
          end
`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
          else if (!g_valid) begin
            if (stall_q == TW'(TIMEOUT - 1)) state_q <= StTerm;
            else stall_q <= stall_q + TW'(1);
          end
`endif
        end
`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
        StTerm: begin
          if (load_term) begin
            m_tvalid_q <= 1'b1;
            state_q    <= StDrop;
          end
        end
        StDrop: begin
          if (g_valid && g_last) begin
            grant_valid_q <= 1'b0;
            state_q       <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  // Payload registers carry no reset; m_tvalid_q qualifies them.
  always_ff @(posedge clk) begin
    if (load_beat) begin
      m_tdata_q <= g_data;
      m_tkeep_q <= (KEEP_ENABLE != 0) ? g_keep : {KEEP_WIDTH{1'b1}};
      m_tlast_q <= g_last;
      m_tuser_q <= g_user;
    end
`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
    else if (load_term) begin
      m_tdata_q <= '0;
      m_tkeep_q <= {KEEP_WIDTH{1'b1}};
      m_tlast_q <= 1'b1;
      m_tuser_q <= USER_BAD_FRAME_VALUE;
    end
`endif
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign grant_valid   = grant_valid_q;
  assign grant_index   = grant_index_q;

endmodule
